// File: rtl/_sipo_register8.sv
// -----------------------------------------------------------------------------
// _sipo_register8
// Serial-in / parallel-out assembler feeding an 8-bit D-flip-flop register.
// Collects WIDTH serial bits under a valid/ready handshake, then presents the
// completed word on p_data with p_valid. The word is held until the
// downstream side accepts it with p_ready.
//
// Parameters
//   WIDTH     : serial bits per parallel word (>= 2)
//   MSB_FIRST : 1 -> first received bit lands in p_data[WIDTH-1]
//               0 -> first received bit lands in p_data[0]
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   s_valid  in   serial bit valid
//   s_data   in   serial bit value
//   s_ready  out  assembler can accept a bit this cycle (decoded from state)
//   flush    in   synchronous discard of a partial word (ignored when FULL)
//   p_valid  out  assembled word available (registered)
//   p_data   out  assembled word, stable while p_valid=1 (registered)
//   p_ready  in   downstream accepts the word this cycle
//   bit_cnt  out  bits collected in the current word (debug, registered)
// -----------------------------------------------------------------------------
module _sipo_register8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  input  logic                       s_data,
  output logic                       s_ready,
  input  logic                       flush,
  output logic                       p_valid,
  output logic [WIDTH-1:0]           p_data,
  input  logic                       p_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_FULL    = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_p_data;
  logic             r_p_valid;
  logic [CW-1:0]    r_bit_cnt;

  logic             w_accept;
  logic             w_last_bit;
  logic [WIDTH-1:0] w_shreg_next;

  // Ready is a pure decode of the state register so it never depends on s_valid.
  always_comb begin
    s_ready = (r_state == ST_COLLECT);
  end

  // Accept qualification and the shift-register next value for the chosen bit order.
  always_comb begin
    w_accept   = s_valid & s_ready;
    w_last_bit = (r_bit_cnt == CW'(WIDTH - 1));
    if (MSB_FIRST) begin
      w_shreg_next = {r_shreg[WIDTH-2:0], s_data};
    end else begin
      w_shreg_next = {s_data, r_shreg[WIDTH-1:1]};
    end
  end

  // Main state, shift register and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_COLLECT;
      r_shreg   <= {WIDTH{1'b0}};
      r_p_data  <= {WIDTH{1'b0}};
      r_p_valid <= 1'b0;
      r_bit_cnt <= {CW{1'b0}};
    end else begin
      case (r_state)
        ST_COLLECT: begin
          // flush wins over a bit presented in the same cycle
          if (flush) begin
            r_shreg   <= {WIDTH{1'b0}};
            r_bit_cnt <= {CW{1'b0}};
          end else if (w_accept) begin
            if (w_last_bit) begin
              // Completed word (including this bit) goes straight to the
              // output register; the shift register restarts clean.
              r_p_data  <= w_shreg_next;
              r_p_valid <= 1'b1;
              r_shreg   <= {WIDTH{1'b0}};
              r_bit_cnt <= {CW{1'b0}};
              r_state   <= ST_FULL;
            end else begin
              r_shreg   <= w_shreg_next;
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
          end else begin
            r_shreg   <= r_shreg;
            r_bit_cnt <= r_bit_cnt;
          end
        end
        ST_FULL: begin
          // Word is held; flush and serial input are ignored here.
          // p_data keeps the last word after the handshake.
          if (r_p_valid & p_ready) begin
            r_p_valid <= 1'b0;
            r_state   <= ST_COLLECT;
          end else begin
            r_p_valid <= r_p_valid;
            r_state   <= r_state;
          end
        end
        default: begin
          r_state   <= ST_COLLECT;
          r_shreg   <= {WIDTH{1'b0}};
          r_p_valid <= 1'b0;
          r_bit_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign p_valid = r_p_valid;
  assign p_data  = r_p_data;
  assign bit_cnt = r_bit_cnt;

endmodule

// File: tb/tb__sipo_register8.sv
// -----------------------------------------------------------------------------
// tb__sipo_register8
// Self-checking bench for _sipo_register8. Two instances share one stimulus
// stream: one with MSB_FIRST=1 and one with MSB_FIRST=0. Expected words are
// pushed into per-instance queues when a word is issued; a monitor pops and
// compares whenever a word is handed off (p_valid & p_ready). Directed
// checks cover reset, hold under backpressure, flush and async reset.
// -----------------------------------------------------------------------------
module tb__sipo_register8;

  logic       clk;
  logic       reset;
  logic       s_valid;
  logic       s_data;
  logic       flush;
  logic       p_ready;

  logic       m_s_ready, l_s_ready;
  logic       m_p_valid, l_p_valid;
  logic [7:0] m_p_data,  l_p_data;
  logic [3:0] m_bit_cnt, l_bit_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_m_q[$];
  logic [7:0] exp_l_q[$];

  _sipo_register8 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
    .s_ready(m_s_ready), .flush(flush), .p_valid(m_p_valid),
    .p_data(m_p_data), .p_ready(p_ready), .bit_cnt(m_bit_cnt)
  );

  _sipo_register8 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
    .s_ready(l_s_ready), .flush(flush), .p_valid(l_p_valid),
    .p_data(l_p_data), .p_ready(p_ready), .bit_cnt(l_bit_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_word(input logic [7:0] wm, input logic [7:0] wl);
    exp_m_q.push_back(wm);
    exp_l_q.push_back(wl);
  endtask

  // Present one bit and hold it until accepted; returns at posedge+1.
  task automatic send_bit(input logic b);
    int  n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    while (!rdy && n < 64) begin
      @(negedge clk);
      rdy = m_s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    if (!rdy) chk("send_bit_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  // Scoreboard monitor: compare on each handoff of each instance.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (!reset) begin
      if (m_p_valid && p_ready) begin
        if (exp_m_q.size() == 0) chk("unexpected_word_msb", {24'd0, m_p_data}, 32'hFFFF_FFFF);
        else begin
          e = exp_m_q.pop_front();
          chk("word_msb_first", {24'd0, m_p_data}, {24'd0, e});
        end
      end
      if (l_p_valid && p_ready) begin
        if (exp_l_q.size() == 0) chk("unexpected_word_lsb", {24'd0, l_p_data}, 32'hFFFF_FFFF);
        else begin
          e = exp_l_q.pop_front();
          chk("word_lsb_first", {24'd0, l_p_data}, {24'd0, e});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b1; s_valid = 1'b0; s_data = 1'b0; flush = 1'b0; p_ready = 1'b1;
    #3;
    chk("reset_s_ready",  {31'd0, m_s_ready}, 32'd1);
    chk("reset_p_valid",  {31'd0, m_p_valid}, 32'd0);
    chk("reset_p_data",   {24'd0, m_p_data},  32'd0);
    chk("reset_bit_cnt",  {28'd0, m_bit_cnt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: A5 back to back, one-cycle p_valid pulse
    expect_word(8'hA5, 8'hA5);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("t1_bit_cnt_3", {28'd0, m_bit_cnt}, 32'd3);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("t1_p_valid_hi", {31'd0, m_p_valid}, 32'd1);
    chk("t1_s_ready_lo", {31'd0, m_s_ready}, 32'd0);
    chk("t1_p_data",     {24'd0, m_p_data},  32'hA5);
    chk("t1_bit_cnt_0",  {28'd0, m_bit_cnt}, 32'd0);
    @(posedge clk); #1;
    chk("t1_p_valid_lo", {31'd0, m_p_valid}, 32'd0);
    chk("t1_s_ready_hi", {31'd0, m_s_ready}, 32'd1);
    chk("t1_p_data_ret", {24'd0, m_p_data},  32'hA5);

    // 2: bits 1,1,0,0,0,0,0,0 -> C0 MSB-first, 03 LSB-first
    expect_word(8'hC0, 8'h03);
    send_word(8'hC0);
    chk("t2_lsb_p_data", {24'd0, l_p_data}, 32'h03);
    @(posedge clk); #1;

    // 3: backpressure on 3C, input held valid, nothing consumed
    p_ready = 1'b0;
    expect_word(8'h3C, 8'h3C);
    send_word(8'h3C);
    s_valid = 1'b1; s_data = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t3_hold_p_valid", {31'd0, m_p_valid}, 32'd1);
      chk("t3_hold_p_data",  {24'd0, m_p_data},  32'h3C);
      chk("t3_hold_s_ready", {31'd0, m_s_ready}, 32'd0);
      chk("t3_hold_bit_cnt", {28'd0, m_bit_cnt}, 32'd0);
    end
    s_valid = 1'b0;
    p_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_release_p_valid", {31'd0, m_p_valid}, 32'd0);
    chk("t3_release_bit_cnt", {28'd0, m_bit_cnt}, 32'd0);
    expect_word(8'h12, 8'h48);
    send_word(8'h12);
    @(posedge clk); #1;

    // 4: flush after 3 bits, then FF; then flush while FULL
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    flush = 1'b1; s_valid = 1'b1; s_data = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; s_valid = 1'b0;
    chk("t4_flush_bit_cnt", {28'd0, m_bit_cnt}, 32'd0);
    expect_word(8'hFF, 8'hFF);
    send_word(8'hFF);
    @(posedge clk); #1;
    p_ready = 1'b0;
    expect_word(8'h0F, 8'hF0);
    send_word(8'h0F);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t4_full_flush_p_valid", {31'd0, m_p_valid}, 32'd1);
    chk("t4_full_flush_p_data",  {24'd0, m_p_data},  32'h0F);
    p_ready = 1'b1;
    @(posedge clk); #1;

    // 5: gapped 96, bit_cnt moves only on accepts
    expect_word(8'h96, 8'h69);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] w;
      w = 8'h96;
      send_bit(w[i]);
      if (i > 0) begin
        chk("t5_bit_cnt_acc", {28'd0, m_bit_cnt}, 32'(8 - i));
        @(posedge clk); #1;
        chk("t5_bit_cnt_gap", {28'd0, m_bit_cnt}, 32'(8 - i));
      end
    end
    chk("t5_p_valid", {31'd0, m_p_valid}, 32'd1);
    @(posedge clk); #1;

    // 6a: async reset after 5 accepts
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("t6_pre_bit_cnt", {28'd0, m_bit_cnt}, 32'd5);
    #3; reset = 1'b1; #1;
    chk("t6a_bit_cnt", {28'd0, m_bit_cnt}, 32'd0);
    chk("t6a_p_data",  {24'd0, m_p_data},  32'd0);
    chk("t6a_s_ready", {31'd0, m_s_ready}, 32'd1);
    chk("t6a_p_valid", {31'd0, m_p_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 6b: async reset while FULL, pending word is lost
    p_ready = 1'b0;
    send_word(8'hE7);
    chk("t6b_pre_p_valid", {31'd0, m_p_valid}, 32'd1);
    #3; reset = 1'b1; #1;
    chk("t6b_p_valid", {31'd0, m_p_valid}, 32'd0);
    chk("t6b_p_data",  {24'd0, m_p_data},  32'd0);
    chk("t6b_bit_cnt", {28'd0, m_bit_cnt}, 32'd0);
    chk("t6b_s_ready", {31'd0, m_s_ready}, 32'd1);
    chk("t6b_lsb_p_data", {24'd0, l_p_data}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    p_ready = 1'b1;

    // recovery word after reset
    expect_word(8'h35, 8'hAC);
    send_word(8'h35);
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_msb_empty", 32'(exp_m_q.size()), 32'd0);
    chk("final_queue_lsb_empty", 32'(exp_l_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
